valid_ready_shift_pipe: RTL and testbench
=========================================

// Module: valid_ready_shift_pipe
//
// PURPOSE
// - Parametrised DEPTH-stage shift pipeline carrying WIDTH-bit transfers.
// - Uses a valid/ready handshake on both sides, so the downstream consumer can stall it.
// - Bubbles collapse: a stalled output does not block empty stages upstream.
// - Adds a synchronous flush and a registered occupancy count.
// - Sits between arithmetic pipeline stages and a consumer that cannot always accept data.
//
// PARAMETERS
// - WIDTH  8  data bits per transfer, >= 1.
// - DEPTH  8  number of register stages, >= 1. DEPTH = 1 must work.
// - CNT_W  localparam, equal to $clog2(DEPTH+1). Width of occupancy.
//
// PORTS
// - clk        in   1      clock; all state updates on posedge.
// - rst        in   1      reset, synchronous, active-high.
// - flush      in   1      discard all held transfers, synchronous.
// - in_vld     in   1      upstream offers in_data.
// - in_rdy     out  1      pipe accepts in_data this cycle.
// - in_data    in   WIDTH  upstream payload.
// - out_vld    out  1      out_data is valid.
// - out_rdy    in   1      downstream accepts out_data this cycle.
// - out_data   out  WIDTH  payload from stage DEPTH-1.
// - occupancy  out  CNT_W  number of valid stages, 0..DEPTH.
//
// BEHAVIOUR
// - State per stage i (0..DEPTH-1): vld[i] and data[i]. Stage DEPTH-1 drives out_vld and out_data.
// - Handshakes: input transfer = in_vld & in_rdy; output transfer = out_vld & out_rdy.
// - Ready chain (combinational):
//   - adv[DEPTH-1] = out_rdy | ~vld[DEPTH-1]
//   - adv[i] = adv[i+1] | ~vld[i]
//   - in_rdy = adv[0] & ~flush & ~rst
// - Stage update when adv[i] is 1:
//   - vld[i] <= vld[i-1]; stage 0 takes in_vld & in_rdy.
//   - data[i] <= data[i-1] only when the source is valid. Otherwise data[i] holds (power saving).
// - Stage update when adv[i] is 0: vld[i] and data[i] hold.
// - Data stability: data and order are never lost, duplicated or reordered.
// - Stall stability: while out_vld=1 and out_rdy=0, out_vld and out_data stay stable.
// - Latency: an accepted transfer into an empty, unstalled pipe appears on out_vld exactly DEPTH cycles later.
// - Throughput: 1 transfer/cycle whenever out_rdy=1.
// - flush=1:
//   - in_rdy=0 and out_vld is masked to 0, so no handshake completes in that cycle.
//   - Next cycle: all vld=0 and occupancy=0.
//   - Data registers are not cleared.
// - occupancy (registered):
//   - +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
//   - Forced to 0 on flush or rst.
//   - Must always equal the popcount of vld.
// - Reset:
//   - vld all 0, so out_vld=0 and occupancy=0.
//   - in_rdy=0 while rst=1.
//   - Data registers are not reset; out_data is don't-care while out_vld=0.
// - Priority: rst > flush > normal operation. Reset mid-stream drops all contents.
// - Full pipe: all vld=1 and out_rdy=0 gives in_rdy=0. If out_rdy=1, in_rdy=1 in the same cycle (pass-through ready).
// - Empty pipe with out_rdy=0: in_rdy=1; data fills from the bottom up.
//
// STRUCTURE
// - Shared package valid_ready_pipe_pkg holds:
//   - function cnt_width(depth), returning $clog2(depth+1);
//   - an assertion macro for the occupancy/popcount invariant.
// - Sub-module valid_ready_pipe_stage holds one vld+data register with load enable.
//   - Inputs: prev_vld, prev_data, adv, flush. Outputs: vld, data.
//   - Instantiated DEPTH times with a generate loop.
// - Top level holds the ready chain, in_rdy/out_vld masking and the occupancy counter.
//
// TESTING
// - Streaming: DEPTH=8, out_rdy=1, in_vld=1 with data 1,2,3,...
//   -> first out_vld 8 cycles after the first accept, then 1,2,3 one per cycle; occupancy stays at 8.
// - Fill under stall: out_rdy=0, push 10 values.
//   -> in_rdy drops after 8 accepts, occupancy=8.
//   -> then out_rdy=1 drains values 1..8 in order; in_rdy returns in the same cycle as out_rdy=1.
// - Bubble collapse: push A, idle 3 cycles, push B, with out_rdy=0.
//   -> A sits in stage 7, B in stage 6, occupancy=2, in_rdy stays 1.
// - Flush mid-stream: occupancy=5 and flush pulsed with in_vld=1 and out_rdy=1.
//   -> no handshake in the flush cycle; next cycle out_vld=0, occupancy=0.
//   -> the next push appears DEPTH cycles later.
// - Reset mid-operation: rst asserted with a full pipe.
//   -> out_vld=0, in_rdy=0 during rst, occupancy=0 after.
//   -> no stale data emitted after rst falls.
// - Random valid/ready, DEPTH in {1,3,8}: scoreboard order match.
//   -> occupancy equals popcount(vld) every cycle; out_data stable while stalled.

Source files
------------

// File: rtl/valid_ready_pipe_pkg.sv
// rtl/valid_ready_pipe_pkg.sv - shared parameters, helpers and checks for the valid/ready shift pipeline
`ifndef VALID_READY_PIPE_PKG_SV
`define VALID_READY_PIPE_PKG_SV

// Occupancy counter must track the number of set stage-valid bits at every clock.
`define VRP_ASSERT_OCC_MATCHES_VLD(clk_s, rst_s, occ_s, vld_s) \
  assert property (@(posedge clk_s) disable iff (rst_s) (int'(occ_s) == $countones(vld_s)))

package valid_ready_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Bits needed to count 0..depth held transfers.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`endif

// File: rtl/valid_ready_pipe_stage.sv
// rtl/valid_ready_pipe_stage.sv - one valid+data register of the shift pipeline
module valid_ready_pipe_stage
  import valid_ready_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  // Valid bit: cleared by flush (the top also routes reset here), otherwise follows the source when advancing.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= prev_vld;
    end
  end

  // Payload moves only when the source carries a transfer; bubbles leave the register untouched.
  always_ff @(posedge clk) begin
    if (!flush && adv && prev_vld) begin
      data <= prev_data;
    end
  end

endmodule

// File: rtl/valid_ready_shift_pipe.sv
// rtl/valid_ready_shift_pipe.sv - DEPTH-stage valid/ready shift pipeline with bubble collapse, flush and occupancy
module valid_ready_shift_pipe
  import valid_ready_pipe_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [CNT_W-1:0]            occ_q;
  logic                        clr;
  logic                        in_xfer;
  logic                        out_xfer;

  // Reset and flush both empty the pipe; reset additionally blocks input.
  assign clr = rst | flush;

  // Ready chain: a stage may advance unless it and every stage below it are full and the consumer stalls.
  // Written as a running "blocked" product from the output end so no vector feeds back on itself.
  always_comb begin : ready_chain
    logic blocked;
    adv     = '1;
    blocked = ~out_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      blocked = blocked & vld[i];
      adv[i]  = ~blocked;
    end
  end

  assign in_rdy   = adv[0] & ~flush & ~rst;
  assign out_vld  = vld[DEPTH-1] & ~clr;
  assign out_data = data[DEPTH-1];
  assign in_xfer  = in_vld & in_rdy;
  assign out_xfer = out_vld & out_rdy;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_vld;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_vld  = in_xfer;
      assign src_data = in_data;
    end else begin : g_body
      assign src_vld  = vld[i-1];
      assign src_data = data[i-1];
    end

    valid_ready_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .flush    (clr),
      .adv      (adv[i]),
      .prev_vld (src_vld),
      .prev_data(src_data),
      .vld      (vld[i]),
      .data     (data[i])
    );
  end

  // Occupancy: up on accept, down on emit, cleared with the pipe contents.
  always_ff @(posedge clk) begin
    if (clr) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_q <= occ_q - CNT_W'(1);
    end
  end

  assign occupancy = occ_q;

  `VRP_ASSERT_OCC_MATCHES_VLD(clk, rst, occ_q, vld);

  // A stalled output must hold its valid and payload until taken or discarded.
  assert property (@(posedge clk) disable iff (clr)
    (out_vld && !out_rdy) |=> (out_vld && $stable(out_data)));

endmodule

// File: tb/tb_valid_ready_shift_pipe.sv
// tb/tb_valid_ready_shift_pipe.sv - scoreboard bench for the valid/ready shift pipeline
module tb_valid_ready_shift_pipe;

  localparam int NDUT = 3;
  localparam int M    = 2;
  localparam int MD   = 8;

  function automatic int depth_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 8);
  endfunction

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NDUT-1:0]           flush;
  logic [NDUT-1:0]           in_vld;
  logic [NDUT-1:0]           in_rdy;
  logic [NDUT-1:0][7:0]      in_data;
  logic [NDUT-1:0]           out_vld;
  logic [NDUT-1:0]           out_rdy;
  logic [NDUT-1:0][7:0]      out_data;
  logic [NDUT-1:0][3:0]      occ;
  logic [7:0]                sb [NDUT][$];
  int                        n_checks;
  int                        n_fail;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int D  = depth_of(k);
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] occ_l;
    valid_ready_shift_pipe #(.WIDTH(8), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush[k]),
      .in_vld(in_vld[k]), .in_rdy(in_rdy[k]), .in_data(in_data[k]),
      .out_vld(out_vld[k]), .out_rdy(out_rdy[k]), .out_data(out_data[k]),
      .occupancy(occ_l));
    assign occ[k] = 4'(occ_l);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    flush = '0; in_vld = '0; out_rdy = '0; in_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = '0; in_vld = '1; out_rdy = '1; in_data = '0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
        n_checks++; if (in_rdy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy dut%0d: got %b expected 0", k, in_rdy[k]); end
        n_checks++; if (out_vld[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld dut%0d: got %b expected 0", k, out_vld[k]); end
        n_checks++; if (occ[k] !== 4'd0) begin n_fail++; $display("FAIL reset_occ dut%0d: got %0d expected 0", k, occ[k]); end
      end
    end
    @(negedge clk);
    rst = 1'b0; idle_all(); #1;
    for (int k = 0; k < NDUT; k++) begin
      n_checks++; if (in_rdy[k] !== 1'b1) begin n_fail++; $display("FAIL empty_in_rdy dut%0d: got %b expected 1", k, in_rdy[k]); end
      sb[k].delete();
    end
  endtask

  task automatic test_streaming();
    int cyc = 0, first_acc = -1, first_out = -1, next_val = 1, n_out = 0;
    out_rdy[M] = 1'b1;
    while (n_out < 20 && cyc < 100) begin
      @(negedge clk);
      in_vld[M] = (next_val <= 20);
      in_data[M] = 8'(next_val);
      #1;
      n_checks++; if (occ[M] !== 4'(sb[M].size())) begin n_fail++; $display("FAIL stream_occ: got %0d expected %0d", occ[M], sb[M].size()); end
      n_checks++; if (in_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL stream_in_rdy: got %b expected 1", in_rdy[M]); end
      if (first_acc >= 0 && cyc >= first_acc + 8 && cyc <= first_acc + 19) begin
        n_checks++; if (occ[M] !== 4'd8) begin n_fail++; $display("FAIL stream_occ_steady: got %0d expected 8", occ[M]); end
      end
      if (out_vld[M] === 1'b1) begin
        if (first_out < 0) first_out = cyc;
        n_checks++;
        if (sb[M].size() == 0) begin n_fail++; $display("FAIL stream_data: got %0h expected nothing", out_data[M]); end
        else begin
          if (out_data[M] !== sb[M][0]) begin n_fail++; $display("FAIL stream_data: got %0h expected %0h", out_data[M], sb[M][0]); end
          void'(sb[M].pop_front());
        end
        n_out++;
      end else if (first_out >= 0) begin
        n_checks++; n_fail++; $display("FAIL stream_tput: got out_vld 0 expected 1 at cycle %0d", cyc);
      end
      if (in_vld[M] && in_rdy[M]) begin
        if (first_acc < 0) first_acc = cyc;
        sb[M].push_back(in_data[M]);
        next_val++;
      end
      cyc++;
    end
    n_checks++; if (n_out != 20) begin n_fail++; $display("FAIL stream_count: got %0d expected 20", n_out); end
    n_checks++; if (first_out - first_acc != MD) begin n_fail++; $display("FAIL stream_latency: got %0d expected %0d", first_out - first_acc, MD); end
    @(negedge clk); idle_all();
  endtask

  task automatic test_fill_stall();
    int next_val = 1, acc = 0, n_out = 0;
    out_rdy[M] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_vld[M] = 1'b1; in_data[M] = 8'(next_val); #1;
      n_checks++; if (occ[M] !== 4'(sb[M].size())) begin n_fail++; $display("FAIL fill_occ: got %0d expected %0d", occ[M], sb[M].size()); end
      n_checks++; if (in_rdy[M] !== (sb[M].size() < MD)) begin n_fail++; $display("FAIL fill_in_rdy: got %b expected %b", in_rdy[M], sb[M].size() < MD); end
      if (in_vld[M] && in_rdy[M]) begin sb[M].push_back(in_data[M]); next_val++; acc++; end
    end
    n_checks++; if (acc != MD) begin n_fail++; $display("FAIL fill_accepts: got %0d expected %0d", acc, MD); end
    for (int d = 0; d < 40 && (sb[M].size() != 0 || next_val <= 10); d++) begin
      @(negedge clk);
      in_vld[M] = (next_val <= 10); in_data[M] = 8'(next_val); out_rdy[M] = 1'b1; #1;
      if (d == 0) begin
        n_checks++; if (occ[M] !== 4'd8) begin n_fail++; $display("FAIL fill_full_occ: got %0d expected 8", occ[M]); end
        n_checks++; if (in_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL fill_pass_rdy: got %b expected 1", in_rdy[M]); end
      end
      if (out_vld[M] === 1'b1) begin
        n_checks++;
        if (sb[M].size() == 0) begin n_fail++; $display("FAIL drain_data: got %0h expected nothing", out_data[M]); end
        else begin
          if (out_data[M] !== sb[M][0]) begin n_fail++; $display("FAIL drain_data: got %0h expected %0h", out_data[M], sb[M][0]); end
          void'(sb[M].pop_front());
        end
        n_out++;
      end
      if (in_vld[M] && in_rdy[M]) begin sb[M].push_back(in_data[M]); next_val++; end
    end
    n_checks++; if (n_out != 10) begin n_fail++; $display("FAIL drain_count: got %0d expected 10", n_out); end
    @(negedge clk); idle_all();
  endtask

  task automatic test_bubble();
    out_rdy[M] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      in_vld[M] = (c == 0 || c == 4); in_data[M] = (c == 0) ? 8'hA5 : 8'h5A; #1;
      n_checks++; if (in_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL bubble_in_rdy: got %b expected 1", in_rdy[M]); end
      if (in_vld[M] && in_rdy[M]) sb[M].push_back(in_data[M]);
    end
    @(negedge clk);
    in_vld[M] = 1'b0; out_rdy[M] = 1'b1; #1;
    n_checks++; if (occ[M] !== 4'd2) begin n_fail++; $display("FAIL bubble_occ: got %0d expected 2", occ[M]); end
    n_checks++; if (out_vld[M] !== 1'b1 || out_data[M] !== 8'hA5) begin n_fail++; $display("FAIL bubble_head: got %b/%0h expected 1/a5", out_vld[M], out_data[M]); end
    if (sb[M].size() != 0) void'(sb[M].pop_front());
    @(negedge clk);
    out_rdy[M] = 1'b0; #1;
    n_checks++; if (out_vld[M] !== 1'b1 || out_data[M] !== 8'h5A) begin n_fail++; $display("FAIL bubble_second: got %b/%0h expected 1/5a", out_vld[M], out_data[M]); end
    n_checks++; if (occ[M] !== 4'd1) begin n_fail++; $display("FAIL bubble_occ1: got %0d expected 1", occ[M]); end
    @(negedge clk);
    out_rdy[M] = 1'b1;
    if (sb[M].size() != 0) void'(sb[M].pop_front());
    @(negedge clk);
    out_rdy[M] = 1'b0; #1;
    n_checks++; if (occ[M] !== 4'd0 || out_vld[M] !== 1'b0) begin n_fail++; $display("FAIL bubble_empty: got %0d/%b expected 0/0", occ[M], out_vld[M]); end
    idle_all();
  endtask

  task automatic test_flush();
    int first_out = -1;
    out_rdy[M] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_vld[M] = 1'b1; in_data[M] = 8'(8'h40 + c); #1;
      if (in_vld[M] && in_rdy[M]) sb[M].push_back(in_data[M]);
    end
    @(negedge clk);
    in_vld[M] = 1'b0; #1;
    n_checks++; if (occ[M] !== 4'd5) begin n_fail++; $display("FAIL flush_pre_occ: got %0d expected 5", occ[M]); end
    @(negedge clk);
    flush[M] = 1'b1; in_vld[M] = 1'b1; in_data[M] = 8'h77; out_rdy[M] = 1'b1; #1;
    n_checks++; if (in_rdy[M] !== 1'b0) begin n_fail++; $display("FAIL flush_in_rdy: got %b expected 0", in_rdy[M]); end
    n_checks++; if (out_vld[M] !== 1'b0) begin n_fail++; $display("FAIL flush_out_vld: got %b expected 0", out_vld[M]); end
    @(negedge clk);
    flush[M] = 1'b0; in_vld[M] = 1'b0; #1;
    sb[M].delete();
    n_checks++; if (out_vld[M] !== 1'b0 || occ[M] !== 4'd0) begin n_fail++; $display("FAIL flush_after: got %b/%0d expected 0/0", out_vld[M], occ[M]); end
    for (int c = 0; c < 20 && first_out < 0; c++) begin
      @(negedge clk);
      in_vld[M] = (c == 0); in_data[M] = 8'h3C; #1;
      if (out_vld[M] === 1'b1) begin
        first_out = c;
        n_checks++; if (out_data[M] !== 8'h3C) begin n_fail++; $display("FAIL flush_repush_data: got %0h expected 3c", out_data[M]); end
      end
    end
    n_checks++; if (first_out != MD) begin n_fail++; $display("FAIL flush_repush_latency: got %0d expected %0d", first_out, MD); end
    @(negedge clk); idle_all();
  endtask

  task automatic test_reset_mid();
    out_rdy[M] = 1'b0;
    for (int c = 0; c < MD; c++) begin
      @(negedge clk);
      in_vld[M] = 1'b1; in_data[M] = 8'(8'hC0 + c); #1;
      n_checks++; if (in_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL rstmid_fill_rdy: got %b expected 1", in_rdy[M]); end
    end
    @(negedge clk);
    in_vld[M] = 1'b1; #1;
    n_checks++; if (occ[M] !== 4'd8 || in_rdy[M] !== 1'b0) begin n_fail++; $display("FAIL rstmid_full: got %0d/%b expected 8/0", occ[M], in_rdy[M]); end
    repeat (2) begin
      @(negedge clk);
      rst = 1'b1; in_vld[M] = 1'b1; out_rdy[M] = 1'b1; #1;
      n_checks++; if (in_rdy[M] !== 1'b0 || out_vld[M] !== 1'b0) begin n_fail++; $display("FAIL rstmid_during: got %b/%b expected 0/0", in_rdy[M], out_vld[M]); end
    end
    @(negedge clk);
    rst = 1'b0; in_vld[M] = 1'b0; #1;
    n_checks++; if (occ[M] !== 4'd0) begin n_fail++; $display("FAIL rstmid_occ: got %0d expected 0", occ[M]); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      n_checks++; if (out_vld[M] !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got %b expected 0 at cycle %0d", out_vld[M], c); end
    end
    for (int k = 0; k < NDUT; k++) sb[k].delete();
    idle_all();
  endtask

  task automatic test_random();
    logic [NDUT-1:0]      pending = '0;
    logic [NDUT-1:0]      prev_stall = '0;
    logic [NDUT-1:0][7:0] prev_data = '0;
    int                   val [NDUT];
    bit                   exp_rdy;
    for (int k = 0; k < NDUT; k++) val[k] = 8'h10 * (k + 1);
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (!pending[k] && $urandom_range(0, 3) != 0) begin
          pending[k] = 1'b1; in_data[k] = 8'(val[k]); val[k]++;
        end
        in_vld[k]  = pending[k];
        out_rdy[k] = ($urandom_range(0, 9) < (((c / 150) % 2 == 1) ? 8 : 3));
        flush[k]   = ($urandom_range(0, 79) == 0);
      end
      #1;
      for (int k = 0; k < NDUT; k++) begin
        n_checks++; if (occ[k] !== 4'(sb[k].size())) begin n_fail++; $display("FAIL rand_occ dut%0d: got %0d expected %0d", k, occ[k], sb[k].size()); end
        exp_rdy = !flush[k] && (out_rdy[k] || sb[k].size() < depth_of(k));
        n_checks++; if (in_rdy[k] !== exp_rdy) begin n_fail++; $display("FAIL rand_in_rdy dut%0d: got %b expected %b", k, in_rdy[k], exp_rdy); end
        if (flush[k]) begin
          n_checks++; if (out_vld[k] !== 1'b0) begin n_fail++; $display("FAIL rand_flush_mask dut%0d: got %b expected 0", k, out_vld[k]); end
        end
        if (prev_stall[k] && !flush[k]) begin
          n_checks++; if (out_vld[k] !== 1'b1 || out_data[k] !== prev_data[k]) begin n_fail++; $display("FAIL rand_stall dut%0d: got %b/%0h expected 1/%0h", k, out_vld[k], out_data[k], prev_data[k]); end
        end
        if (out_vld[k] === 1'b1) begin
          n_checks++;
          if (sb[k].size() == 0) begin n_fail++; $display("FAIL rand_data dut%0d: got %0h expected nothing", k, out_data[k]); end
          else if (out_data[k] !== sb[k][0]) begin n_fail++; $display("FAIL rand_data dut%0d: got %0h expected %0h", k, out_data[k], sb[k][0]); end
        end
        prev_stall[k] = out_vld[k] && !out_rdy[k];
        prev_data[k]  = out_data[k];
        if (out_vld[k] && out_rdy[k] && sb[k].size() != 0) void'(sb[k].pop_front());
        if (in_vld[k] && in_rdy[k]) begin sb[k].push_back(in_data[k]); pending[k] = 1'b0; end
        if (flush[k]) sb[k].delete();
      end
    end
    @(negedge clk); idle_all();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; idle_all();
    test_reset();
    test_streaming();
    test_fill_stall();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
